// File: rtl/wb_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_stage_if
// Description : Memory-stage handshake, data-bus read response and GPR
//               write-port bundle for the write-back stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_stage_if;
   // memory stage -> write-back
   logic        ms_valid;
   logic        ws_allowin;
   logic        ms_wen;
   logic [4:0]  ms_wreg;
   logic [31:0] ms_res;
   logic [2:0]  ms_load;
   logic [1:0]  ms_addr_lo;
   logic [31:0] ms_rt_val;
   // data-bus read response
   logic        data_ok;
   logic [31:0] rdata;
   // GPR write port and hazard information
   logic        wen;
   logic [4:0]  wreg;
   logic [31:0] wdata;
   logic        ws_busy;
   logic [4:0]  ws_wreg;

   // Upstream side: memory stage, data bus and the consumers of the results
   modport master (
      output ms_valid, ms_wen, ms_wreg, ms_res, ms_load, ms_addr_lo, ms_rt_val,
      output data_ok, rdata,
      input  ws_allowin, wen, wreg, wdata, ws_busy, ws_wreg
   );

   // Write-back stage side
   modport slave (
      input  ms_valid, ms_wen, ms_wreg, ms_res, ms_load, ms_addr_lo, ms_rt_val,
      input  data_ok, rdata,
      output ws_allowin, wen, wreg, wdata, ws_busy, ws_wreg
   );
endinterface
`default_nettype wire

// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : wb_stage
// Description : MIPS write-back stage. Holds one retiring instruction, waits
//               for its load response if needed, extends/merges load data and
//               drives the GPR write port for exactly one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_stage (
   input  wire logic  clk,
   input  wire logic  resetn,
   wb_stage_if.slave  bus
);

   localparam logic [2:0] LD_NONE = 3'd0;
   localparam logic [2:0] LD_LB   = 3'd1;
   localparam logic [2:0] LD_LBU  = 3'd2;
   localparam logic [2:0] LD_LH   = 3'd3;
   localparam logic [2:0] LD_LHU  = 3'd4;
   localparam logic [2:0] LD_LW   = 3'd5;
   localparam logic [2:0] LD_LWL  = 3'd6;
   localparam logic [2:0] LD_LWR  = 3'd7;

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } state_t;

   state_t      state_q,    state_d;
   logic        ws_valid_q, ws_valid_d;
   logic        ws_wen_q,   ws_wen_d;
   logic [4:0]  ws_wreg_q,  ws_wreg_d;
   logic [31:0] ws_res_q,   ws_res_d;
   logic [2:0]  ws_load_q,  ws_load_d;
   logic [1:0]  ws_lo_q,    ws_lo_d;
   logic [31:0] ws_rt_q,    ws_rt_d;

   logic        ws_done;
   logic        ws_allowin;
   logic        accept;
   logic        wen_int;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] result;

   // The held instruction retires now: either it never needed memory, or the
   // load response is arriving this cycle. Stray data_ok in IDLE is harmless
   // because an IDLE instruction is done regardless.
   assign ws_done    = ws_valid_q && ((state_q == S_IDLE) || bus.data_ok);
   assign ws_allowin = !ws_valid_q || ws_done;
   assign accept     = bus.ms_valid && ws_allowin;

   // State register and captured instruction fields
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= S_IDLE;
         ws_valid_q <= 1'b0;
         ws_wen_q   <= 1'b0;
         ws_wreg_q  <= 5'd0;
         ws_res_q   <= 32'd0;
         ws_load_q  <= LD_NONE;
         ws_lo_q    <= 2'd0;
         ws_rt_q    <= 32'd0;
      end else begin
         state_q    <= state_d;
         ws_valid_q <= ws_valid_d;
         ws_wen_q   <= ws_wen_d;
         ws_wreg_q  <= ws_wreg_d;
         ws_res_q   <= ws_res_d;
         ws_load_q  <= ws_load_d;
         ws_lo_q    <= ws_lo_d;
         ws_rt_q    <= ws_rt_d;
      end
   end

   // Next-state: capture on accept (back-to-back in the done cycle), otherwise
   // drop the instruction once it is done
   always_comb begin
      state_d    = state_q;
      ws_valid_d = ws_valid_q;
      ws_wen_d   = ws_wen_q;
      ws_wreg_d  = ws_wreg_q;
      ws_res_d   = ws_res_q;
      ws_load_d  = ws_load_q;
      ws_lo_d    = ws_lo_q;
      ws_rt_d    = ws_rt_q;
      if (accept) begin
         ws_valid_d = 1'b1;
         ws_wen_d   = bus.ms_wen;
         ws_wreg_d  = bus.ms_wreg;
         ws_res_d   = bus.ms_res;
         ws_load_d  = bus.ms_load;
         ws_lo_d    = bus.ms_addr_lo;
         ws_rt_d    = bus.ms_rt_val;
         state_d    = (bus.ms_load != LD_NONE) ? S_WAIT : S_IDLE;
      end else if (ws_done) begin
         ws_valid_d = 1'b0;
         state_d    = S_IDLE;
      end
   end

   // Load data extraction and write-back result selection
   always_comb begin
      ld_byte = 8'd0;
      ld_half = ws_lo_q[1] ? bus.rdata[31:16] : bus.rdata[15:0];
      result  = ws_res_q;
      case (ws_lo_q)
         2'd0:    ld_byte = bus.rdata[7:0];
         2'd1:    ld_byte = bus.rdata[15:8];
         2'd2:    ld_byte = bus.rdata[23:16];
         default: ld_byte = bus.rdata[31:24];
      endcase
      case (ws_load_q)
         LD_LB:   result = {{24{ld_byte[7]}}, ld_byte};
         LD_LBU:  result = {24'd0, ld_byte};
         LD_LH:   result = {{16{ld_half[15]}}, ld_half};
         LD_LHU:  result = {16'd0, ld_half};
         LD_LW:   result = bus.rdata;
         LD_LWL: begin
            case (ws_lo_q)
               2'd0:    result = {bus.rdata[7:0],  ws_rt_q[23:0]};
               2'd1:    result = {bus.rdata[15:0], ws_rt_q[15:0]};
               2'd2:    result = {bus.rdata[23:0], ws_rt_q[7:0]};
               default: result = bus.rdata;
            endcase
         end
         LD_LWR: begin
            case (ws_lo_q)
               2'd0:    result = bus.rdata;
               2'd1:    result = {ws_rt_q[31:24], bus.rdata[31:8]};
               2'd2:    result = {ws_rt_q[31:16], bus.rdata[31:16]};
               default: result = {ws_rt_q[31:8],  bus.rdata[31:24]};
            endcase
         end
         default: result = ws_res_q;
      endcase
   end

   // r0 writes are suppressed here so the register file never sees them
   assign wen_int        = ws_done && ws_wen_q && (ws_wreg_q != 5'd0);
   assign bus.wen        = wen_int;
   assign bus.wreg       = wen_int ? ws_wreg_q : 5'd0;
   assign bus.wdata      = wen_int ? result : 32'd0;
   assign bus.ws_allowin = ws_allowin;
   assign bus.ws_busy    = ws_valid_q && ws_wen_q && !ws_done;
   assign bus.ws_wreg    = ws_valid_q ? ws_wreg_q : 5'd0;

endmodule
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_stage
// Description : Self-checking bench for wb_stage: vector table of load
//               extension/merge cases, directed multi-cycle sequences and a
//               randomized run against a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_stage;

   logic clk;
   logic resetn;
   int   checks;
   int   errors;

   wb_stage_if bus ();

   wb_stage dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  load;
      logic [1:0]  lo;
      logic [31:0] rt;
      logic [31:0] rd;
      logic [31:0] exp;
   } vec_t;

   typedef struct {
      logic        wen;
      logic [4:0]  wreg;
      logic [31:0] res;
      logic [2:0]  load;
      logic [1:0]  lo;
      logic [31:0] rt;
   } instr_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%08h required=%08h @%0t", name, act, exp, $time);
      end
   endtask

   // Reference result: loads described as byte/halfword picks and shifted merges
   function automatic logic [31:0] model_result(input instr_t i, input logic [31:0] rd);
      logic [31:0] b;
      logic [31:0] h;
      int          sh;
      b  = (rd >> (8 * i.lo)) & 32'hFF;
      h  = (rd >> (16 * i.lo[1])) & 32'hFFFF;
      case (i.load)
         3'd0: return i.res;
         3'd1: return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
         3'd2: return b;
         3'd3: return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
         3'd4: return h;
         3'd5: return rd;
         3'd6: begin
            sh = 8 * (3 - i.lo);
            return (rd << sh) | (i.rt & ((32'd1 << sh) - 32'd1));
         end
         default: begin
            sh = 8 * i.lo;
            return (rd >> sh) | (i.rt & ~(32'hFFFF_FFFF >> sh));
         end
      endcase
   endfunction

   task automatic drive_idle();
      bus.ms_valid   = 1'b0;
      bus.ms_wen     = 1'b0;
      bus.ms_wreg    = 5'd0;
      bus.ms_res     = 32'd0;
      bus.ms_load    = 3'd0;
      bus.ms_addr_lo = 2'd0;
      bus.ms_rt_val  = 32'd0;
      bus.data_ok    = 1'b0;
      bus.rdata      = 32'd0;
   endtask

   task automatic drive_instr(input logic wen, input logic [4:0] wreg, input logic [31:0] res,
                              input logic [2:0] load, input logic [1:0] lo, input logic [31:0] rt);
      bus.ms_valid   = 1'b1;
      bus.ms_wen     = wen;
      bus.ms_wreg    = wreg;
      bus.ms_res     = res;
      bus.ms_load    = load;
      bus.ms_addr_lo = lo;
      bus.ms_rt_val  = rt;
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_wen"},     {31'd0, bus.wen},        32'd0);
      chk({tag, "_wreg"},    {27'd0, bus.wreg},       32'd0);
      chk({tag, "_wdata"},   bus.wdata,               32'd0);
      chk({tag, "_busy"},    {31'd0, bus.ws_busy},    32'd0);
      chk({tag, "_ws_wreg"}, {27'd0, bus.ws_wreg},    32'd0);
      chk({tag, "_allowin"}, {31'd0, bus.ws_allowin}, 32'd1);
   endtask

   task automatic chk_write(input string tag, input logic [4:0] wreg, input logic [31:0] wdata);
      chk({tag, "_wen"},   {31'd0, bus.wen},  32'd1);
      chk({tag, "_wreg"},  {27'd0, bus.wreg}, {27'd0, wreg});
      chk({tag, "_wdata"}, bus.wdata,         wdata);
   endtask

   task automatic do_reset();
      @(negedge clk);
      drive_idle();
      resetn = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
   endtask

   vec_t   vecs[11];
   instr_t pend_q[$];
   instr_t nxt;
   logic [31:0] rd_r;
   logic   dok;
   logic   done_m;
   logic   allow_m;
   logic   wen_m;

   initial begin
      checks = 0;
      errors = 0;
      vecs[0]  = '{3'd1, 2'd2, 32'h0,         32'h80FF7F01, 32'hFFFFFFFF};
      vecs[1]  = '{3'd2, 2'd3, 32'h0,         32'h80FF7F01, 32'h00000080};
      vecs[2]  = '{3'd3, 2'd2, 32'h0,         32'h80FF7F01, 32'hFFFF80FF};
      vecs[3]  = '{3'd4, 2'd0, 32'h0,         32'h80FF7F01, 32'h00007F01};
      vecs[4]  = '{3'd6, 2'd1, 32'hAABBCCDD,  32'h11223344, 32'h3344CCDD};
      vecs[5]  = '{3'd7, 2'd2, 32'hAABBCCDD,  32'h11223344, 32'hAABB1122};
      vecs[6]  = '{3'd5, 2'd0, 32'h0,         32'hDEADBEEF, 32'hDEADBEEF};
      vecs[7]  = '{3'd6, 2'd0, 32'hAABBCCDD,  32'h11223344, 32'h44BBCCDD};
      vecs[8]  = '{3'd7, 2'd3, 32'hAABBCCDD,  32'h11223344, 32'hAABBCC11};
      vecs[9]  = '{3'd1, 2'd0, 32'h0,         32'h80FF7F01, 32'h00000001};
      vecs[10] = '{3'd2, 2'd1, 32'h0,         32'h80FF7F01, 32'h0000007F};

      // ---------------- reset state ----------------
      drive_idle();
      resetn = 1'b0;
      #2;
      chk_quiet("reset");
      @(negedge clk);
      resetn = 1'b1;

      // ---------------- non-load stream ----------------
      @(negedge clk);
      drive_instr(1'b1, 5'd3, 32'h11, 3'd0, 2'd0, 32'd0);
      #1 chk("alu0_allowin", {31'd0, bus.ws_allowin}, 32'd1);
      @(negedge clk);
      drive_instr(1'b1, 5'd4, 32'h22, 3'd0, 2'd0, 32'd0);
      #1 chk_write("alu_r3", 5'd3, 32'h11);
      chk("alu1_allowin", {31'd0, bus.ws_allowin}, 32'd1);
      @(negedge clk);
      drive_instr(1'b1, 5'd5, 32'h33, 3'd0, 2'd0, 32'd0);
      #1 chk_write("alu_r4", 5'd4, 32'h22);
      chk("alu2_allowin", {31'd0, bus.ws_allowin}, 32'd1);
      @(negedge clk);
      drive_idle();
      #1 chk_write("alu_r5", 5'd5, 32'h33);
      @(negedge clk);
      #1 chk_quiet("alu_end");

      // ---------------- load stall with back-to-back accept ----------------
      @(negedge clk);
      drive_instr(1'b1, 5'd8, 32'h0, 3'd5, 2'd0, 32'd0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         drive_idle();
         #1;
         chk("stall_busy",    {31'd0, bus.ws_busy},    32'd1);
         chk("stall_allowin", {31'd0, bus.ws_allowin}, 32'd0);
         chk("stall_wen",     {31'd0, bus.wen},        32'd0);
         chk("stall_ws_wreg", {27'd0, bus.ws_wreg},    32'd8);
      end
      @(negedge clk);
      bus.data_ok = 1'b1;
      bus.rdata   = 32'hDEADBEEF;
      drive_instr(1'b1, 5'd9, 32'h99, 3'd0, 2'd0, 32'd0);
      #1 chk_write("lw_r8", 5'd8, 32'hDEADBEEF);
      chk("lw_allowin", {31'd0, bus.ws_allowin}, 32'd1);
      chk("lw_busy",    {31'd0, bus.ws_busy},    32'd0);
      @(negedge clk);
      drive_idle();
      #1 chk_write("after_lw_r9", 5'd9, 32'h99);
      @(negedge clk);
      #1 chk_quiet("lw_end");

      // ---------------- extension / merge vector table ----------------
      for (int v = 0; v < 11; v++) begin
         @(negedge clk);
         drive_instr(1'b1, 5'd10 + 5'(v), 32'h5A5A5A5A, vecs[v].load, vecs[v].lo, vecs[v].rt);
         @(negedge clk);
         drive_idle();
         bus.data_ok = 1'b1;
         bus.rdata   = vecs[v].rd;
         #1 chk_write($sformatf("vec%0d", v), 5'd10 + 5'(v), vecs[v].exp);
      end
      @(negedge clk);
      drive_idle();
      #1 chk_quiet("vec_end");

      // ---------------- r0 destination ----------------
      @(negedge clk);
      drive_instr(1'b1, 5'd0, 32'h12345678, 3'd0, 2'd0, 32'd0);
      @(negedge clk);
      drive_idle();
      #1 chk("r0_wen",     {31'd0, bus.wen},        32'd0);
      chk("r0_wdata",      bus.wdata,               32'd0);
      chk("r0_allowin",    {31'd0, bus.ws_allowin}, 32'd1);
      @(negedge clk);
      #1 chk_quiet("r0_end");

      // ---------------- reset mid-WAIT, late data_ok ignored ----------------
      @(negedge clk);
      drive_instr(1'b1, 5'd7, 32'h0, 3'd5, 2'd0, 32'd0);
      @(negedge clk);
      drive_idle();
      #1 chk("pre_rst_busy", {31'd0, bus.ws_busy}, 32'd1);
      #2 resetn = 1'b0;
      #1 chk_quiet("mid_rst");
      @(negedge clk);
      resetn = 1'b1;
      bus.data_ok = 1'b1;
      bus.rdata   = 32'hCAFEF00D;
      #1 chk_quiet("stray_dok");
      @(negedge clk);
      drive_idle();

      // ---------------- randomized run against transaction model ----------------
      do_reset();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         rd_r = $urandom;
         dok  = ($urandom_range(0, 2) == 0);
         bus.data_ok = dok;
         bus.rdata   = rd_r;
         if ($urandom_range(0, 3) != 0) begin
            nxt.wen  = ($urandom_range(0, 7) != 0);
            nxt.wreg = 5'($urandom_range(0, 31));
            nxt.res  = $urandom;
            nxt.load = $urandom_range(0, 1) ? 3'd0 : 3'($urandom_range(1, 7));
            nxt.lo   = 2'($urandom_range(0, 3));
            nxt.rt   = $urandom;
            drive_instr(nxt.wen, nxt.wreg, nxt.res, nxt.load, nxt.lo, nxt.rt);
         end else begin
            bus.ms_valid = 1'b0;
         end
         #1;
         done_m  = (pend_q.size() != 0) && ((pend_q[0].load == 3'd0) || dok);
         allow_m = (pend_q.size() == 0) || done_m;
         wen_m   = done_m && pend_q[0].wen && (pend_q[0].wreg != 5'd0);
         chk("rnd_allowin", {31'd0, bus.ws_allowin}, {31'd0, allow_m});
         chk("rnd_wen",     {31'd0, bus.wen},        {31'd0, wen_m});
         if (wen_m) begin
            chk("rnd_wreg",  {27'd0, bus.wreg}, {27'd0, pend_q[0].wreg});
            chk("rnd_wdata", bus.wdata,         model_result(pend_q[0], rd_r));
         end else begin
            chk("rnd_wdata_idle", bus.wdata, 32'd0);
         end
         chk("rnd_busy", {31'd0, bus.ws_busy},
             {31'd0, (pend_q.size() != 0) && pend_q[0].wen && !done_m});
         chk("rnd_ws_wreg", {27'd0, bus.ws_wreg},
             (pend_q.size() != 0) ? {27'd0, pend_q[0].wreg} : 32'd0);
         if (done_m) void'(pend_q.pop_front());
         if (bus.ms_valid && allow_m) pend_q.push_back(nxt);
      end

      @(negedge clk);
      drive_idle();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/wb_stage.md
# wb_stage

Write-back stage of the in-order MIPS pipeline and sole driver of the GPR file's write port (`wen`/`wreg`/`wdata`). It accepts one retiring instruction per handshake from the memory stage and holds it while a load response is outstanding on the data bus. It extracts and sign/zero-extends load data, including LWL/LWR merging, then presents the result for exactly one cycle. Because the GPR file bypasses its write port to its read ports, the value driven here is visible to decode in the same cycle.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  core clock; all state updates on rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `ms_valid`  in  1  memory stage holds a valid instruction.
- `ws_allowin`  out  1  WB can accept an instruction this cycle.
- `ms_wen`  in  1  instruction writes a GPR.
- `ms_wreg`  in  5  destination register number.
- `ms_res`  in  32  ALU/move result, used for non-loads.
- `ms_load`  in  3  load type: 0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 LWL, 7 LWR.
- `ms_addr_lo`  in  2  byte offset of the load address.
- `ms_rt_val`  in  32  old rt value, used for LWL/LWR merge.
- `data_ok`  in  1  data-bus read response valid.
- `rdata`  in  32  data-bus read word, valid when `data_ok`=1.
- `wen`  out  1  GPR write enable.
- `wreg`  out  5  GPR written.
- `wdata`  out  32  value written.
- `ws_busy`  out  1  WB holds an instruction with `ms_wen`=1 that has not written yet. Used by hazard logic together with `ws_wreg`.
- `ws_wreg`  out  5  destination of the held instruction.

## Operation
- Registers: `ws_valid`, `state` (IDLE, WAIT), and captured copies of `ms_wen`, `ms_wreg`, `ms_res`, `ms_load`, `ms_addr_lo`, `ms_rt_val`.
- **Accept:** the instruction is accepted when `ms_valid && ws_allowin`. On the next edge, `ws_valid`=1 and the fields are captured.
  - Load: state goes to WAIT.
  - Otherwise: state goes to IDLE.
- **Done signal:** `ws_done` = `ws_valid && (state==IDLE || data_ok)`.
- **Allow-in:** `ws_allowin` = `!ws_valid || ws_done`, so a back-to-back accept occurs in the done cycle.
- **Leaving WB:** when `ws_done` and no new accept, `ws_valid` clears and state goes to IDLE.
- **Write-port outputs:**
  - `wen` = `ws_done && ws_wen && ws_wreg!=0`.
  - `wreg` = `ws_wreg` when `wen`, else 0.
  - `wdata` = result when `wen`, else 0.
- **Result selection:** non-load uses `ws_res`. For loads, with byte `b=rdata[8*lo+7:8*lo]` and halfword `h=rdata[16*lo[1]+15:16*lo[1]]`:
  - LB: sign-extend `b`. LBU: zero-extend `b`.
  - LH: sign-extend `h`. LHU: zero-extend `h`.
  - LW: `rdata`.
  - LWL by offset lo:
    - lo=0: {rdata[7:0], rt[23:0]}
    - lo=1: {rdata[15:0], rt[15:0]}
    - lo=2: {rdata[23:0], rt[7:0]}
    - lo=3: rdata
  - LWR by offset lo:
    - lo=0: rdata
    - lo=1: {rt[31:24], rdata[31:8]}
    - lo=2: {rt[31:16], rdata[31:16]}
    - lo=3: {rt[31:8], rdata[31:24]}
- **Hazard outputs:** `ws_busy` = `ws_valid && ws_wen && !wen_pending_done`, i.e. asserted while in WAIT with `data_ok`=0. `ws_wreg` = captured `wreg`, 0 when `!ws_valid`.
- **Load with `ms_wen`=0 or `wreg`=0:** still waits for `data_ok` and retires without writing.
- **Stray `data_ok`:** ignored in IDLE or when `ws_valid`=0.

## Timing
- **Reset:** asynchronous. `ws_valid`=0, state IDLE, all captured fields 0. Outputs during reset: `wen`=0, `wreg`=0, `wdata`=0, `ws_busy`=0, `ws_wreg`=0, `ws_allowin`=1.
- **Non-load latency:** accept at edge N; `wen`=1 throughout cycle N+1; the GPR is updated at edge N+2 and readable via bypass during N+1.
- **Load latency:** `wen` is asserted in the first cycle with `state==WAIT && data_ok`, combinationally from `rdata`. The response is guaranteed no earlier than the cycle after accept.
- **Throughput:** one instruction per cycle for consecutive non-loads.
- **Write pulse:** exactly one `wen` pulse per retiring instruction; never two for the same instruction.
- **Reset mid-WAIT:** the instruction is discarded with no write, and a later `data_ok` is ignored.

## Test plan
- **Reset:** assert `resetn`=0 mid-cycle → all outputs 0 immediately, `ws_allowin`=1.
- **Non-load stream:** three back-to-back ALU ops writing r3=0x11, r4=0x22, r5=0x33 → `wen` high on three consecutive cycles with matching `wreg`/`wdata`; `ws_allowin` stays 1.
- **Load stall:** LW r8 with `data_ok` delayed 3 cycles, `rdata`=0xDEADBEEF.
  - `ws_busy`=1 and `ws_allowin`=0 for 3 cycles.
  - Then `wen`=1, `wdata`=0xDEADBEEF for one cycle, with a new accept in that cycle.
- **Extension:** `rdata`=0x80FF7F01:
  - LB lo=2 → 0xFFFFFFFF; LBU lo=3 → 0x00000080.
  - LH lo=2 → 0xFFFF80FF; LHU lo=0 → 0x00007F01.
- **Merge:** `rt`=0xAABBCCDD, `rdata`=0x11223344:
  - LWL lo=1 → 0x3344CCDD.
  - LWR lo=2 → 0xAABB1122.
- **r0 destination:** ALU op with wreg=0 → `wen` stays 0, instruction still retires and `ws_allowin` returns to 1.
